// File: rtl/layer_ctrl_fsm.sv
// Host-command controller for the accelerator core: edge-qualified command decode,
// single-op launch with start/DMA pulses, watchdog, completion interrupt and layer chaining.
module layer_ctrl_fsm #(
    parameter int                 NUM_OPS    = 4,
    parameter int                 CTRL_W     = 4,
    parameter logic [NUM_OPS-1:0] RD_MASK    = 4'b1111,
    parameter logic [NUM_OPS-1:0] WR_MASK    = 4'b1110,
    parameter logic [NUM_OPS-1:0] CHAIN_MASK = 4'b1110,
    parameter int                 TO_W       = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTRL_W-1:0]  control,
    input  logic [NUM_OPS-1:0] complete,
    input  logic [TO_W-1:0]    timeout_cycles,
    output logic [1:0]         state,
    output logic [NUM_OPS-1:0] active_op,
    output logic [NUM_OPS-1:0] start,
    output logic               dma_rd_valid,
    output logic               dma_wr_valid,
    output logic               irq,
    output logic               err,
    output logic               busy,
    output logic               next_layer,
    output logic [15:0]        layer_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [CTRL_W-1:0] CODE_ACK   = {CTRL_W{1'b1}};
    localparam logic [CTRL_W-1:0] CODE_ABORT = {{(CTRL_W-1){1'b1}}, 1'b0};

    state_t             state_q, state_d;
    logic [CTRL_W-1:0]  control_q;
    logic [NUM_OPS-1:0] active_op_q, active_op_d;
    logic [NUM_OPS-1:0] start_q, start_d;
    logic               dma_rd_q, dma_rd_d;
    logic               dma_wr_q, dma_wr_d;
    logic               next_layer_q, next_layer_d;
    logic [15:0]        layer_count_q, layer_count_d;
    logic [TO_W-1:0]    watchdog_q, watchdog_d;

    logic [NUM_OPS-1:0] code_onehot;
    logic               new_cmd;
    logic               start_cmd;
    logic               ack_cmd;
    logic               abort_cmd;
    logic               op_done;
    logic               timed_out;

    // Start code k+1 maps to one-hot op k; codes outside 1..NUM_OPS give all zeros.
    always_comb begin
        code_onehot = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            code_onehot[k] = (control == CTRL_W'(k + 1));
        end
    end

    assign new_cmd   = (control != control_q);
    assign start_cmd = new_cmd && (|code_onehot);
    assign ack_cmd   = new_cmd && (control == CODE_ACK);
    assign abort_cmd = new_cmd && (control == CODE_ABORT);
    assign op_done   = |(complete & active_op_q);
    assign timed_out = (timeout_cycles != '0) && (watchdog_q == timeout_cycles - TO_W'(1));

    always_comb begin
        state_d       = state_q;
        active_op_d   = active_op_q;
        start_d       = '0;
        dma_rd_d      = 1'b0;
        dma_wr_d      = 1'b0;
        next_layer_d  = 1'b0;
        layer_count_d = layer_count_q;
        watchdog_d    = watchdog_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    state_d     = S_RUN;
                    active_op_d = code_onehot;
                    start_d     = code_onehot;
                    dma_rd_d    = |(code_onehot & RD_MASK);
                    dma_wr_d    = |(code_onehot & WR_MASK);
                    watchdog_d  = '0;
                end
            end
            // Completion outranks abort, which outranks the watchdog.
            S_RUN: begin
                if (op_done) begin
                    state_d = S_DONE;
                end else if (abort_cmd) begin
                    state_d     = S_IDLE;
                    active_op_d = '0;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    watchdog_d = watchdog_q + TO_W'(1);
                end
            end
            S_DONE: begin
                if (ack_cmd) begin
                    state_d     = S_IDLE;
                    active_op_d = '0;
                    if (|(active_op_q & CHAIN_MASK)) begin
                        next_layer_d  = 1'b1;
                        layer_count_d = layer_count_q + 16'd1;
                    end
                end
            end
            S_ERR: begin
                if (ack_cmd) begin
                    state_d     = S_IDLE;
                    active_op_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                active_op_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            control_q     <= '0;
            active_op_q   <= '0;
            start_q       <= '0;
            dma_rd_q      <= 1'b0;
            dma_wr_q      <= 1'b0;
            next_layer_q  <= 1'b0;
            layer_count_q <= '0;
            watchdog_q    <= '0;
        end else begin
            state_q       <= state_d;
            control_q     <= control;
            active_op_q   <= active_op_d;
            start_q       <= start_d;
            dma_rd_q      <= dma_rd_d;
            dma_wr_q      <= dma_wr_d;
            next_layer_q  <= next_layer_d;
            layer_count_q <= layer_count_d;
            watchdog_q    <= watchdog_d;
        end
    end

    assign state        = state_q;
    assign active_op    = active_op_q;
    assign start        = start_q;
    assign dma_rd_valid = dma_rd_q;
    assign dma_wr_valid = dma_wr_q;
    assign next_layer   = next_layer_q;
    assign layer_count  = layer_count_q;
    assign busy         = (state_q != S_IDLE);
    assign irq          = (state_q == S_DONE) || (state_q == S_ERR);
    assign err          = (state_q == S_ERR);

endmodule

// File: tb/tb_layer_ctrl_fsm.sv
// Directed bench for layer_ctrl_fsm: a command-level model is checked every cycle,
// and hand-computed literals pin key points of each scenario.
module tb_layer_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  control;
    logic [3:0]  complete;
    logic [19:0] timeout_cycles;
    logic [1:0]  state;
    logic [3:0]  active_op;
    logic [3:0]  start;
    logic        dma_rd_valid;
    logic        dma_wr_valid;
    logic        irq;
    logic        err;
    logic        busy;
    logic        next_layer;
    logic [15:0] layer_count;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [3:0] rd_mask    = 4'b1111;
    logic [3:0] wr_mask    = 4'b1110;
    logic [3:0] chain_mask = 4'b1110;

    // Model: mode uses the state output numbering, op is -1 when nothing is running,
    // run_cycles is the number of RUN cycles that have fully elapsed.
    int         m_mode       = 0;
    int         m_op         = -1;
    int         m_run_cycles = 0;
    int         m_count      = 0;
    int         m_start      = 0;
    int         m_rd         = 0;
    int         m_wr         = 0;
    int         m_next       = 0;
    logic [3:0] m_prev       = 4'd0;

    int          preset_seq  = 0;
    int          preset_seen = 0;
    logic [15:0] preset_val  = 16'd0;

    layer_ctrl_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .control        (control),
        .complete       (complete),
        .timeout_cycles (timeout_cycles),
        .state          (state),
        .active_op      (active_op),
        .start          (start),
        .dma_rd_valid   (dma_rd_valid),
        .dma_wr_valid   (dma_wr_valid),
        .irq            (irq),
        .err            (err),
        .busy           (busy),
        .next_layer     (next_layer),
        .layer_count    (layer_count)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit is_new;
        if (preset_seq != preset_seen) begin
            m_count     = int'(preset_val);
            preset_seen = preset_seq;
        end
        m_start = 0;
        m_rd    = 0;
        m_wr    = 0;
        m_next  = 0;
        if (rst) begin
            m_mode       = 0;
            m_op         = -1;
            m_run_cycles = 0;
            m_count      = 0;
            m_prev       = 4'd0;
        end else begin
            is_new = (control != m_prev);
            m_prev = control;
            case (m_mode)
                0: if (is_new && control >= 4'd1 && control <= 4'd4) begin
                    m_op         = int'(control) - 1;
                    m_mode       = 1;
                    m_run_cycles = 0;
                    m_start      = 1 << m_op;
                    m_rd         = int'(rd_mask[m_op]);
                    m_wr         = int'(wr_mask[m_op]);
                end
                1: begin
                    if (complete[m_op]) begin
                        m_mode = 2;
                    end else if (is_new && control == 4'hE) begin
                        m_mode = 0;
                        m_op   = -1;
                    end else begin
                        m_run_cycles++;
                        if (timeout_cycles != 0 && m_run_cycles == int'(timeout_cycles)) m_mode = 3;
                    end
                end
                2: if (is_new && control == 4'hF) begin
                    if (chain_mask[m_op]) begin
                        m_next  = 1;
                        m_count = (m_count + 1) % 65536;
                    end
                    m_mode = 0;
                    m_op   = -1;
                end
                3: if (is_new && control == 4'hF) begin
                    m_mode = 0;
                    m_op   = -1;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic compare_model();
        check_output("state",        int'(state),        m_mode);
        check_output("active_op",    int'(active_op),    (m_op < 0) ? 0 : (1 << m_op));
        check_output("start",        int'(start),        m_start);
        check_output("dma_rd_valid", int'(dma_rd_valid), m_rd);
        check_output("dma_wr_valid", int'(dma_wr_valid), m_wr);
        check_output("busy",         int'(busy),         (m_mode != 0) ? 1 : 0);
        check_output("irq",          int'(irq),          (m_mode >= 2) ? 1 : 0);
        check_output("err",          int'(err),          (m_mode == 3) ? 1 : 0);
        check_output("next_layer",   int'(next_layer),   m_next);
        check_output("layer_count",  int'(layer_count),  m_count);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic apply_stimulus(input logic [3:0] ctrl, input logic [3:0] cmpl);
        control  = ctrl;
        complete = cmpl;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst            = 1'b1;
        control        = 4'd0;
        complete       = 4'd0;
        timeout_cycles = 20'd0;
        apply_stimulus(4'd0, 4'd0);
        apply_stimulus(4'd0, 4'd0);
        check_output("lit reset state", int'(state), 0);
        check_output("lit reset count", int'(layer_count), 0);
        rst = 1'b0;
        apply_stimulus(4'd0, 4'd0);

        // Op 1: launch, complete five cycles later, ACK chains a layer.
        apply_stimulus(4'd2, 4'd0);
        check_output("lit op1 start", int'(start), 4'b0010);
        check_output("lit op1 dma_rd", int'(dma_rd_valid), 1);
        check_output("lit op1 dma_wr", int'(dma_wr_valid), 1);
        check_output("lit op1 active", int'(active_op), 4'b0010);
        apply_stimulus(4'd2, 4'd0);
        check_output("lit op1 start gone", int'(start), 0);
        repeat (3) apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'b0010);
        check_output("lit op1 irq", int'(irq), 1);
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit op1 next_layer", int'(next_layer), 1);
        check_output("lit op1 count", int'(layer_count), 1);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit op1 next_layer gone", int'(next_layer), 0);

        // Op 0: read-only DMA, not chained.
        apply_stimulus(4'd1, 4'd0);
        check_output("lit op0 dma_wr", int'(dma_wr_valid), 0);
        check_output("lit op0 dma_rd", int'(dma_rd_valid), 1);
        apply_stimulus(4'd1, 4'b0001);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit op0 next_layer", int'(next_layer), 0);
        check_output("lit op0 count", int'(layer_count), 1);

        // Watchdog: exactly ten RUN cycles, then a completion in the tenth cycle wins.
        timeout_cycles = 20'd10;
        apply_stimulus(4'd3, 4'd0);
        repeat (9) apply_stimulus(4'd3, 4'd0);
        check_output("lit wd still run", int'(state), 1);
        apply_stimulus(4'd3, 4'd0);
        check_output("lit wd err state", int'(state), 3);
        check_output("lit wd err", int'(err), 1);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit wd ack state", int'(state), 0);
        check_output("lit wd count", int'(layer_count), 1);
        apply_stimulus(4'd3, 4'd0);
        repeat (9) apply_stimulus(4'd3, 4'd0);
        apply_stimulus(4'd3, 4'b0100);
        check_output("lit wd late done", int'(state), 2);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit wd chain count", int'(layer_count), 2);
        timeout_cycles = 20'd0;

        // Held codes never retrigger; ABORT returns silently.
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'b0010);
        repeat (3) apply_stimulus(4'd2, 4'd0);
        check_output("lit hold done", int'(state), 2);
        apply_stimulus(4'hF, 4'd0);
        repeat (3) apply_stimulus(4'hF, 4'd0);
        check_output("lit hold ack idle", int'(state), 0);
        check_output("lit hold ack count", int'(layer_count), 3);
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'hE, 4'd0);
        check_output("lit abort state", int'(state), 0);
        check_output("lit abort irq", int'(irq), 0);
        repeat (2) apply_stimulus(4'hE, 4'd0);

        // Foreign completion ignored; completion beats a simultaneous ABORT.
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'b1000);
        check_output("lit foreign complete", int'(state), 1);
        apply_stimulus(4'hE, 4'b0010);
        check_output("lit done beats abort", int'(state), 2);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit count after race", int'(layer_count), 4);

        // Reset mid-run with the start code held, then relaunch right after reset.
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'd0);
        rst = 1'b1;
        apply_stimulus(4'd2, 4'd0);
        check_output("lit rst state", int'(state), 0);
        check_output("lit rst active", int'(active_op), 0);
        check_output("lit rst count", int'(layer_count), 0);
        rst = 1'b0;
        apply_stimulus(4'd2, 4'd0);
        check_output("lit relaunch start", int'(start), 4'b0010);
        apply_stimulus(4'd2, 4'b0010);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit relaunch count", int'(layer_count), 1);

        // Preload the layer counter near its limit to exercise the wrap.
        #2;
        force dut.layer_count_q = 16'hFFFE;
        preset_val = 16'hFFFE;
        preset_seq++;
        apply_stimulus(4'hF, 4'd0);
        #2;
        release dut.layer_count_q;
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'b0010);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit count ffff", int'(layer_count), 16'hFFFF);
        apply_stimulus(4'd2, 4'd0);
        apply_stimulus(4'd2, 4'b0010);
        apply_stimulus(4'hF, 4'd0);
        check_output("lit count wrap", int'(layer_count), 0);
        check_output("lit wrap next_layer", int'(next_layer), 1);
        apply_stimulus(4'hF, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
